// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg
//   Shared definitions for the memory bus controller: default bus widths,
//   default acknowledge timeout and the controller state encoding.
package mem_bus_ctrl_pkg;

  localparam int unsigned DEF_ADDRESS_BUS_WIDTH = 16;
  localparam int unsigned DEF_DATA_BUS_WIDTH    = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES    = 15;  // legal range 1..255

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr
//   Counts ACCESS cycles for the memory bus controller and flags the cycle in
//   which the acknowledge budget is exhausted.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       restart the count from zero (transaction accepted)
//   enable      count this cycle (controller is in ACCESS)
//   expired     high while the count equals TIMEOUT_CYCLES-1
module bus_timeout_ctr
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // The count starts at zero in the first ACCESS cycle, so this marks the
  // TIMEOUT_CYCLES-th ACCESS cycle.
  assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
//   Latches the muxed address / write data, runs one req/ack transaction on
//   the memory bus, returns read data and pulses done (with error on timeout).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, we           transaction request and direction (sampled in IDLE)
//   addr_in, wdata_in   address / write data from the upstream muxes
//   busy, done, error   status: not idle, completion pulse, timeout pulse
//   rdata_out           last successfully read word
//   mem_addr, mem_wdata latched address / write data to memory
//   mem_we, mem_req     memory write enable (qualified) and request
//   mem_ack, mem_rdata  memory acknowledge and read data
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned ADDRESS_BUS_WIDTH = DEF_ADDRESS_BUS_WIDTH,
  parameter int unsigned DATA_BUS_WIDTH    = DEF_DATA_BUS_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         we,
  input  logic [ADDRESS_BUS_WIDTH-1:0] addr_in,
  input  logic [DATA_BUS_WIDTH-1:0]    wdata_in,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [DATA_BUS_WIDTH-1:0]    rdata_out,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_addr,
  output logic [DATA_BUS_WIDTH-1:0]    mem_wdata,
  output logic                         mem_we,
  output logic                         mem_req,
  input  logic                         mem_ack,
  input  logic [DATA_BUS_WIDTH-1:0]    mem_rdata
);

  state_e                         state_q, state_d;
  logic                           err_q, err_d;
  logic                           we_q;
  logic [ADDRESS_BUS_WIDTH-1:0]   addr_q;
  logic [DATA_BUS_WIDTH-1:0]      wdata_q;
  logic [DATA_BUS_WIDTH-1:0]      rdata_q;
  logic                           accept;
  logic                           expired;

  assign accept = (state_q == ST_IDLE) && start;

  bus_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (state_q == ST_ACCESS),
    .expired(expired)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; ack takes priority over a coinciding timeout
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (mem_ack) begin
          state_d = ST_DONE;
        end else if (expired) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decode the state register only, so no input reaches an output
  always_comb begin
    busy    = (state_q != ST_IDLE);
    mem_req = (state_q == ST_ACCESS);
    mem_we  = (state_q == ST_ACCESS) && we_q;
    done    = (state_q == ST_DONE);
    error   = (state_q == ST_DONE) && err_q;
  end

  // Request latches, error flag and read-data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr_in;
        wdata_q <= wdata_in;
      end
      if (state_q == ST_ACCESS) begin
        err_q <= err_d;
        if (mem_ack && !we_q) rdata_q <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata_out = rdata_q;

endmodule
